// File: rtl/id_ex_ctrl.sv
// Opcode decoder and ID/EX control register with freeze/flush handling
// and a saturating count of illegal opcodes seen in ID.
module id_ex_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [5:0]       opcode,
  input  logic             freeze,
  input  logic             flush,
  output logic             ex_valid,
  output logic [3:0]       EXE_CMD,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             wb_en,
  output logic             is_imm,
  output logic [1:0]       br_type,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       imm;
    logic [1:0] br;
  } ctrl_t;

  ctrl_t dec, ctrl_q;
  logic  legal;
  logic  vld_q, ill_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      6'd0:  ;
      6'd1:  dec = '{cmd: 4'b0000, wb: 1'b1, default: '0};
      6'd3:  dec = '{cmd: 4'b0010, wb: 1'b1, default: '0};
      6'd5:  dec = '{cmd: 4'b0100, wb: 1'b1, default: '0};
      6'd6:  dec = '{cmd: 4'b0101, wb: 1'b1, default: '0};
      6'd7:  dec = '{cmd: 4'b0110, wb: 1'b1, default: '0};
      6'd8:  dec = '{cmd: 4'b0111, wb: 1'b1, default: '0};
      6'd9,
      6'd10: dec = '{cmd: 4'b1000, wb: 1'b1, default: '0};
      6'd11: dec = '{cmd: 4'b1001, wb: 1'b1, default: '0};
      6'd12: dec = '{cmd: 4'b1010, wb: 1'b1, default: '0};
      6'd32: dec = '{cmd: 4'b0000, wb: 1'b1, imm: 1'b1, default: '0};
      6'd33: dec = '{cmd: 4'b0010, wb: 1'b1, imm: 1'b1, default: '0};
      6'd36: dec = '{mem_r: 1'b1, wb: 1'b1, imm: 1'b1, default: '0};
      6'd37: dec = '{mem_w: 1'b1, imm: 1'b1, default: '0};
      6'd40: dec = '{br: 2'b01, default: '0};
      6'd41: dec = '{br: 2'b10, default: '0};
      6'd42: dec = '{br: 2'b11, default: '0};
      default: legal = 1'b0;
    endcase
  end

  // Illegal opcodes load the inert NOP vector with ex_valid low so EX ignores them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else if (!freeze) begin
      if (instr_valid) begin
        ctrl_q <= dec;
        vld_q  <= legal;
        ill_q  <= ~legal;
        if (!legal && cnt_q != '1)
          cnt_q <= cnt_q + 1'b1;
      end else begin
        ctrl_q <= '0;
        vld_q  <= 1'b0;
        ill_q  <= 1'b0;
      end
    end
  end

  assign ex_valid      = vld_q;
  assign EXE_CMD       = ctrl_q.cmd;
  assign mem_r_en      = ctrl_q.mem_r;
  assign mem_w_en      = ctrl_q.mem_w;
  assign wb_en         = ctrl_q.wb;
  assign is_imm        = ctrl_q.imm;
  assign br_type       = ctrl_q.br;
  assign illegal       = ill_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Directed-vector bench for id_ex_ctrl; control outputs are packed as
// {ex_valid, EXE_CMD, mem_r, mem_w, wb, imm, br_type, illegal}.
module tb_id_ex_ctrl;
  logic       clk = 1'b0;
  logic       rst, instr_valid, freeze, flush;
  logic [5:0] opcode;
  logic       ex_valid, mem_r_en, mem_w_en, wb_en, is_imm, illegal;
  logic [3:0] EXE_CMD;
  logic [1:0] br_type;
  logic [7:0] illegal_count;

  int n_vec = 0;
  int n_bad = 0;

  id_ex_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .freeze(freeze), .flush(flush), .ex_valid(ex_valid), .EXE_CMD(EXE_CMD),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .is_imm(is_imm),
    .br_type(br_type), .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] vec();
    return {ex_valid, EXE_CMD, mem_r_en, mem_w_en, wb_en, is_imm, br_type, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [11:0] BUBBLE = 12'h000;
  localparam logic [11:0] ILL    = 12'h001;

  logic [5:0]  ops [18] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                            6'd11, 6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42};
  logic [11:0] exps[18] = '{12'h800, 12'h810, 12'h910, 12'hA10, 12'hA90, 12'hB10,
                            12'hB90, 12'hC10, 12'hC10, 12'hC90, 12'hD10, 12'h818,
                            12'h918, 12'h858, 12'h828, 12'h802, 12'h804, 12'h806};

  initial begin
    rst = 1'b1; instr_valid = 1'b0; freeze = 1'b0; flush = 1'b0; opcode = 6'd0;
    step(); step();
    chk("reset_vec", 32'(vec()), 32'(BUBBLE));
    chk("reset_cnt", 32'(illegal_count), 32'd0);

    rst = 1'b0; instr_valid = 1'b1; opcode = 6'd1;
    step();
    chk("first_add", 32'(vec()), 32'h810);

    for (int i = 0; i < 18; i++) begin
      opcode = ops[i];
      step();
      chk($sformatf("sweep_op%0d", ops[i]), 32'(vec()), 32'(exps[i]));
    end

    instr_valid = 1'b0;
    step();
    chk("no_instr_bubble", 32'(vec()), 32'(BUBBLE));

    instr_valid = 1'b1; opcode = 6'd37;
    step();
    chk("st_load", 32'(vec()), 32'h828);
    freeze = 1'b1; opcode = 6'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("freeze_hold%0d", i), 32'(vec()), 32'h828);
    end
    freeze = 1'b0;
    step();
    chk("after_freeze_sub", 32'(vec()), 32'h910);

    flush = 1'b1; freeze = 1'b1; opcode = 6'd41;
    step();
    chk("flush_freeze", 32'(vec()), 32'(BUBBLE));
    flush = 1'b0; freeze = 1'b0;
    chk("cnt_zero_legal", 32'(illegal_count), 32'd0);

    opcode = 6'd63;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 1) begin
        chk("ill_vec", 32'(vec()), 32'(ILL));
        chk("ill_cnt1", 32'(illegal_count), 32'd1);
      end
      if (i == 255) chk("ill_cnt255", 32'(illegal_count), 32'd255);
    end
    chk("ill_sat_vec", 32'(vec()), 32'(ILL));
    chk("ill_sat_cnt", 32'(illegal_count), 32'd255);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_clr_cnt", 32'(illegal_count), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("cnt5", 32'(illegal_count), 32'd5);

    freeze = 1'b1;
    step(); step();
    chk("freeze_ill_vec", 32'(vec()), 32'(ILL));
    chk("freeze_no_cnt", 32'(illegal_count), 32'd5);
    freeze = 1'b0; flush = 1'b1;
    step();
    chk("flush_ill_vec", 32'(vec()), 32'(BUBBLE));
    chk("flush_no_cnt", 32'(illegal_count), 32'd5);
    flush = 1'b0; freeze = 1'b1;
    step();
    chk("freeze_bubble", 32'(vec()), 32'(BUBBLE));
    chk("freeze_cnt5", 32'(illegal_count), 32'd5);

    rst = 1'b1; opcode = 6'd1;
    step();
    chk("midrst_vec", 32'(vec()), 32'(BUBBLE));
    chk("midrst_cnt", 32'(illegal_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
